// File: rtl/parity_error_logger_if.sv
// Sample-in / record-out bus of the parity error logger.
// Master drives checked samples and consumes records; slave is the logger.
interface parity_error_logger_if;
  logic       in_valid;
  logic [3:0] in_addr;
  logic [7:0] in_data;
  logic       in_match;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_addr;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_addr, in_data, in_match, out_ready,
    input  out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_match, out_ready,
    output out_valid, out_addr, out_data
  );
endinterface

// File: rtl/parity_error_logger.sv
// Logs parity mismatches into a small record FIFO and keeps error statistics.
// Define PARITY_LOG_SATURATE_EN to make err_count saturate instead of wrapping.
module parity_error_logger #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ALARM_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  parity_error_logger_if.slave     bus,
  input  logic                     clear_stats,
  output logic [CNT_W-1:0]         err_count,
  output logic                     dropped,
  output logic                     alarm,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [11:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, err_base;
  logic             dropped_q, dropped_d;
  logic             alarm_q, alarm_d;
  logic             err_event, full, empty, pop, push, drop;

  assign err_event = bus.in_valid & ~bus.in_match;
  assign full      = (count_q == (PtrW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = ~empty & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = err_event & (~full | pop);
  assign drop      = err_event & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // An error event coinciding with clear_stats counts from zero.
  always_comb begin
    err_base    = clear_stats ? '0 : err_count_q;
    err_count_d = err_base;
    if (err_event) begin
`ifdef PARITY_LOG_SATURATE_EN
      if (err_base != '1) err_count_d = err_base + 1'b1;
`else
      err_count_d = err_base + 1'b1;
`endif
    end
    dropped_d = (clear_stats ? 1'b0 : dropped_q) | drop;
    alarm_d   = (32'(err_count_d) >= ALARM_THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
      dropped_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      dropped_q   <= dropped_d;
      alarm_q     <= alarm_d;
    end
  end

  // Head is read from storage flops, so a new record shows up one cycle after its event.
  assign bus.out_valid = ~empty;
  assign bus.out_addr  = mem_q[rd_ptr_q][11:8];
  assign bus.out_data  = mem_q[rd_ptr_q][7:0];
  assign err_count     = err_count_q;
  assign dropped       = dropped_q;
  assign alarm         = alarm_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_parity_error_logger.sv
// Self-checking bench for parity_error_logger: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_parity_error_logger;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int THRESH = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PARITY_LOG_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_stats, clear_stats2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic       dropped, dropped2, alarm, alarm2;
  logic [2:0] fifo_count, fifo_count2;

  parity_error_logger_if bus ();
  parity_error_logger_if bus2 ();

  parity_error_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ALARM_THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clear_stats(clear_stats),
    .err_count(err_count), .dropped(dropped), .alarm(alarm), .fifo_count(fifo_count)
  );

  parity_error_logger #(.DEPTH(4), .CNT_W(2), .ALARM_THRESH(2)) dut_lim (
    .clk(clk), .reset(reset), .bus(bus2), .clear_stats(clear_stats2),
    .err_count(err_count2), .dropped(dropped2), .alarm(alarm2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [11:0] rec_q [$];
  int          m_cnt;
  bit          m_drop, m_alarm;

  task automatic cycle(input logic v, input logic [3:0] a, input logic [7:0] d,
                       input logic m, input logic rdy, input logic clr, input logic rst);
    bit err, pop, full, drop_now;
    bus.in_valid = v; bus.in_addr = a; bus.in_data = d; bus.in_match = m;
    bus.out_ready = rdy; clear_stats = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      rec_q.delete(); m_cnt = 0; m_drop = 0; m_alarm = 0;
    end else begin
      err = v && !m;
      pop = (rec_q.size() > 0) && rdy;
      full = (rec_q.size() == DEPTH);
      drop_now = 0;
      if (pop) void'(rec_q.pop_front());
      if (err) begin
        if (!full || pop) rec_q.push_back({a, d});
        else drop_now = 1;
      end
      if (clr) begin m_cnt = 0; m_drop = 0; end
      if (err) m_cnt = SAT ? ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1) : (m_cnt + 1) % (CNT_MAX + 1);
      m_drop = m_drop | drop_now;
      m_alarm = (m_cnt >= THRESH);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, rdy, 1'b0, 1'b0);
  endtask

  task automatic err_ev(input logic [3:0] a, input logic [7:0] d, input logic rdy);
    cycle(1'b1, a, d, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 4'h5, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h6, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 7;
    if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    if (bus.out_addr !== 4'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h want 0", bus.out_addr); end
    if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
  endtask

  task automatic test_single();
    do_reset();
    err_ev(4'h9, 8'h23, 1'b0);
    n_checks += 4;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    if (bus.out_addr !== 4'h9) begin n_fail++; $display("FAIL single_out_addr: got %h want 9", bus.out_addr); end
    if (bus.out_data !== 8'h23) begin n_fail++; $display("FAIL single_out_data: got %h want 23", bus.out_data); end
    if (err_count !== 8'd1) begin n_fail++; $display("FAIL single_err_count: got %0d want 1", err_count); end
    // Holds while not accepted
    idle(1'b0);
    n_checks += 1;
    if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 4'h9, 8'h23}) begin
      n_fail++; $display("FAIL single_hold: got %h want 1923", {bus.out_valid, bus.out_addr, bus.out_data});
    end
    // in_match ignored when in_valid is low
    cycle(1'b0, 4'h1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks += 1;
    if (err_count !== 8'd1) begin n_fail++; $display("FAIL invalid_ignored: got %0d want 1", err_count); end
  endtask

  task automatic test_overflow();
    logic [11:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) err_ev(4'(i + 3), 8'(8'hA0 + i), 1'b0);
    n_checks += 4;
    if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_fifo_count: got %0d want 4", fifo_count); end
    if (dropped !== 1'b1) begin n_fail++; $display("FAIL ovf_dropped: got %b want 1", dropped); end
    if (err_count !== 8'd5) begin n_fail++; $display("FAIL ovf_err_count: got %0d want 5", err_count); end
    if (alarm !== 1'b1) begin n_fail++; $display("FAIL ovf_alarm: got %b want 1", alarm); end
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks += 3;
    if ({dropped, alarm, err_count} !== 10'd0) begin
      n_fail++; $display("FAIL ovf_clear_stats: got %b%b/%0d want 00/0", dropped, alarm, err_count);
    end
    if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_clear_keeps_fifo: got %0d want 4", fifo_count); end
    if (bus.out_addr !== 4'h3) begin n_fail++; $display("FAIL ovf_clear_keeps_head: got %h want 3", bus.out_addr); end
    for (int i = 0; i < 4; i++) begin
      want = {4'(i + 3), 8'(8'hA0 + i)};
      n_checks += 1;
      if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, want}) begin
        n_fail++; $display("FAIL ovf_drain_%0d: got %h want %h", i, {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, want});
      end
      idle(1'b1);
    end
    n_checks += 1;
    if (bus.out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL ovf_empty: got valid=%b count=%0d want 0/0", bus.out_valid, fifo_count);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) err_ev(4'(i), 8'(8'h10 + i), 1'b0);
    err_ev(4'hF, 8'hEE, 1'b1);
    n_checks += 4;
    if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_fifo_count: got %0d want 4", fifo_count); end
    if (dropped !== 1'b0) begin n_fail++; $display("FAIL fpp_dropped: got %b want 0", dropped); end
    if (err_count !== 8'd5) begin n_fail++; $display("FAIL fpp_err_count: got %0d want 5", err_count); end
    if ({bus.out_addr, bus.out_data} !== 12'h111) begin
      n_fail++; $display("FAIL fpp_head: got %h want 111", {bus.out_addr, bus.out_data});
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_checks += 1;
    if ({bus.out_addr, bus.out_data} !== 12'hFEE) begin
      n_fail++; $display("FAIL fpp_tail: got %h want fee", {bus.out_addr, bus.out_data});
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) err_ev(4'h7, 8'(i), 1'b0);
    n_checks += 1;
    if (err_count !== 8'd3) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 3", err_count); end
    // Push and pop cancel, so fifo_count must not move.
    cycle(1'b1, 4'hC, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks += 3;
    if (err_count !== 8'd1) begin n_fail++; $display("FAIL clr_err_count: got %0d want 1", err_count); end
    if (alarm !== 1'b0) begin n_fail++; $display("FAIL clr_alarm: got %b want 0", alarm); end
    if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL clr_fifo_count: got %0d want 3", fifo_count); end
  endtask

  task automatic test_counter_limit();
    int exp_cnt, exp_alarm;
    do_reset();
    bus2.in_valid = 1'b1; bus2.in_match = 1'b0; bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_addr = 4'(i); bus2.in_data = 8'(i);
      idle(1'b1);
    end
    bus2.in_valid = 1'b0;
    exp_cnt = SAT ? ((5 > 3) ? 3 : 5) : 5 % 4;
    exp_alarm = (exp_cnt >= 2) ? 1 : 0;
    n_checks += 2;
    if (err_count2 !== 2'(exp_cnt)) begin n_fail++; $display("FAIL limit_err_count: got %0d want %0d", err_count2, exp_cnt); end
    if (alarm2 !== 1'(exp_alarm)) begin n_fail++; $display("FAIL limit_alarm: got %b want %0d", alarm2, exp_alarm); end
  endtask

  task automatic test_random();
    logic [11:0] head;
    bit v, m, rdy, clr, rst;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 9) < 6);
      m = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle(v, 4'($urandom), 8'($urandom), m, rdy, clr, rst);
      n_checks += 5;
      if (fifo_count !== 3'(rec_q.size())) begin
        n_fail++; $display("FAIL rnd_fifo_count @%0d: got %0d want %0d", n, fifo_count, rec_q.size());
      end
      if (err_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_err_count @%0d: got %0d want %0d", n, err_count, m_cnt); end
      if (dropped !== m_drop) begin n_fail++; $display("FAIL rnd_dropped @%0d: got %b want %b", n, dropped, m_drop); end
      if (alarm !== m_alarm) begin n_fail++; $display("FAIL rnd_alarm @%0d: got %b want %b", n, alarm, m_alarm); end
      if (bus.out_valid !== (rec_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_out_valid @%0d: got %b want %b", n, bus.out_valid, rec_q.size() > 0);
      end
      if (rec_q.size() > 0) begin
        head = rec_q[0];
        n_checks += 1;
        if ({bus.out_addr, bus.out_data} !== head) begin
          n_fail++; $display("FAIL rnd_head @%0d: got %h want %h", n, {bus.out_addr, bus.out_data}, head);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear_stats = 1'b0; clear_stats2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_match = 1'b1; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_addr = '0; bus2.in_data = '0; bus2.in_match = 1'b1; bus2.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_counter_limit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_error_logger.md
PARITY_ERROR_LOGGER -- requirements
Module: parity_error_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of error-record FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the error-counter width.
REQ-003 SHALL have parameter ALARM_THRESH, default 4, meaning the error count at which alarm asserts.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state on posedge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the checked sample on in_* is valid this cycle.
REQ-007 SHALL have port in_addr, input, 4 bits: fetch address (bit 3 = bank select, bits 2:0 = word).
REQ-008 SHALL have port in_data, input, 8 bits: fetched data byte.
REQ-009 SHALL have port in_match, input, 1 bit: parity-checker result (1 = parity OK).
REQ-010 SHALL have port clear_stats, input, 1 bit: synchronous clear of err_count, dropped and alarm.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the head record.
REQ-012 SHALL have port out_valid, output, 1 bit: a head record is present.
REQ-013 SHALL have port out_addr, output, 4 bits: head record address.
REQ-014 SHALL have port out_data, output, 8 bits: head record data.
REQ-015 SHALL have port err_count, output, CNT_W bits: total mismatches seen.
REQ-016 SHALL have port dropped, output, 1 bit: sticky flag, a record was lost because the FIFO was full.
REQ-017 SHALL have port alarm, output, 1 bit: err_count >= ALARM_THRESH.
REQ-018 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: number of stored records.

Function
REQ-019 SHALL define an error event as in_valid=1 and in_match=0 in the same cycle; in_match SHALL be ignored when in_valid=0.
REQ-020 SHALL increment err_count by 1 on every error event, whether or not the record is stored.
REQ-021 SHALL push {in_addr, in_data} into the FIFO on an error event when the FIFO is not full.
REQ-022 SHALL discard the record on an error event when the FIFO is full and no pop occurs, and SHALL set dropped on the next edge.
REQ-023 SHALL pop the head record on a cycle where out_valid=1 and out_ready=1.
REQ-024 SHALL accept both the push and the pop when they occur in the same cycle while the FIFO is full, with fifo_count unchanged and no drop.
REQ-025 SHALL register the FIFO output with no fall-through: a record pushed into an empty FIFO SHALL appear on out_valid/out_addr/out_data one cycle after the error event.
REQ-026 SHALL hold out_addr and out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL wrap the FIFO read and write pointers modulo DEPTH, and SHALL derive full/empty from fifo_count.
REQ-028 SHALL register alarm, setting it on the edge at which err_count becomes >= ALARM_THRESH.
REQ-029 SHALL, on clear_stats=1, load err_count=0, dropped=0 and alarm=0, and SHALL leave the FIFO contents untouched.
REQ-030 SHALL give an error event priority when it coincides with clear_stats: err_count=1 after the edge, and dropped=1 if that event is dropped.

Reset
REQ-031 SHALL, while reset=1 at a posedge, set out_valid=0, fifo_count=0, err_count=0, dropped=0, alarm=0 and both FIFO pointers to 0.
REQ-032 SHALL give reset priority over every other input, including mid-operation; records stored before reset SHALL be lost.
REQ-033 SHALL drive out_addr=0 and out_data=0 after reset, until the first push.

Configuration
REQ-034 SHALL, when macro PARITY_LOG_SATURATE_EN is defined, hold err_count at all-ones on further error events.
REQ-035 SHALL, when PARITY_LOG_SATURATE_EN is undefined, wrap err_count from all-ones to 0, with alarm then recomputed from the wrapped value.

Verification
REQ-036 SHALL cover a reset scenario: reset=1 for 2 cycles with in_valid=1, in_match=0 -> err_count=0, out_valid=0, fifo_count=0.
REQ-037 SHALL cover single-error latency: one error event with addr=4'h9, data=8'h23 -> next cycle out_valid=1, out_addr=9, out_data=8'h23, err_count=1.
REQ-038 SHALL cover overflow: out_ready=0 and 5 consecutive error events with DEPTH=4 -> fifo_count=4, dropped=1, err_count=5, alarm=1; drain order equals push order of the first 4 records.
REQ-039 SHALL cover full with simultaneous push and pop: FIFO full, out_ready=1 and an error event in the same cycle -> fifo_count stays 4, dropped stays 0.
REQ-040 SHALL cover clear with a coincident error: err_count=3, clear_stats=1 with an error event -> err_count=1, alarm=0, fifo_count unchanged.
REQ-041 SHALL cover counter limit: CNT_W=2 with 5 error events -> err_count=3 with PARITY_LOG_SATURATE_EN defined, err_count=1 without it.
